// File: rtl/axi4_activity_led_array_pkg.sv
// Shared types and mode encodings for the AXI4 activity LED indicator.
package axi4_activity_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd1, S_GAP = 2'd2} chan_state_t;
  localparam int MODE_RETRIGGER = 0;
  localparam int MODE_BLINK     = 1;
endpackage

// File: rtl/axi4_activity_led_array_if.sv
// AR/AW address-handshake bundle for N monitored AXI slots.
interface axi4_activity_led_array_if #(parameter int N_SLOTS = 3);
  logic [N_SLOTS-1:0] slot_arvalid;
  logic [N_SLOTS-1:0] slot_arready;
  logic [N_SLOTS-1:0] slot_awvalid;
  logic [N_SLOTS-1:0] slot_awready;

  modport master (output slot_arvalid, slot_arready, slot_awvalid, slot_awready);
  // The indicator is a passive tap: it only ever observes the handshake.
  modport slave  (input  slot_arvalid, slot_arready, slot_awvalid, slot_awready);
endinterface

// File: rtl/axi4_activity_led_array_pulse_chan.sv
// One LED channel: stretches single-cycle activity into a visible pulse (retrigger or blink).
module axi4_activity_pulse_chan
  import axi4_activity_pkg::*;
#(
  parameter int PULSE_LEN_CYCLES = 25_000_000,
  parameter int GAP_LEN_CYCLES   = 12_500_000,
  parameter int MODE             = MODE_RETRIGGER
) (
  input  logic clk,
  input  logic reset_n,
  input  logic act,
  output logic led_on
);
  localparam int MAX_LEN = (PULSE_LEN_CYCLES > GAP_LEN_CYCLES) ? PULSE_LEN_CYCLES : GAP_LEN_CYCLES;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] PULSE_END = CW'(PULSE_LEN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_LEN_CYCLES - 1);

  chan_state_t   state;
  logic [CW-1:0] cntr;
  logic          pending;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cntr    <= '0;
      pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (act) begin
          state <= S_ON;
          cntr  <= '0;
        end
        S_ON: if (MODE == MODE_RETRIGGER) begin
          // activity wins over pulse end, keeping the LED solid
          if (act)                    cntr <= '0;
          else if (cntr >= PULSE_END) begin state <= S_IDLE; cntr <= '0; end
          else                        cntr <= cntr + 1'b1;
        end else begin
          if (act) pending <= 1'b1;
          if (cntr >= PULSE_END) begin state <= S_GAP; cntr <= '0; end
          else                          cntr <= cntr + 1'b1;
        end
        S_GAP: if (cntr >= GAP_END) begin
          state   <= (pending | act) ? S_ON : S_IDLE;
          cntr    <= '0;
          pending <= 1'b0;
        end else begin
          cntr <= cntr + 1'b1;
          if (act) pending <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          cntr    <= '0;
          pending <= 1'b0;
        end
      endcase
    end
  end

  assign led_on = (state == S_ON);
endmodule

// File: rtl/axi4_activity_led_array.sv
// N-slot AXI4 AR/AW activity monitor driving per-slot and aggregate LEDs.
module axi4_activity_led_array
  import axi4_activity_pkg::*;
#(
  parameter int N_SLOTS          = 3,
  parameter int PULSE_LEN_CYCLES = 25_000_000,
  parameter int GAP_LEN_CYCLES   = 12_500_000,
  parameter int MODE             = MODE_RETRIGGER,
  parameter int LED_ACTIVE_LOW   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  axi4_activity_led_array_if.slave  bus,
  output logic [N_SLOTS-1:0]        led_slot,
  output logic                      led_rd,
  output logic                      led_wr,
  output logic                      led_any
);
  localparam int  N_CHAN = N_SLOTS + 3;
  localparam bit  INV    = (LED_ACTIVE_LOW != 0);

  logic [N_SLOTS-1:0] ar, aw;
  logic [N_CHAN-1:0]  chan_act, chan_led;

  assign ar = bus.slot_arvalid & bus.slot_arready;
  assign aw = bus.slot_awvalid & bus.slot_awready;

  // channel order: slots, then rd, wr, any
  assign chan_act = {(|ar) | (|aw), |aw, |ar, ar | aw};

  genvar i;
  generate
    for (i = 0; i < N_CHAN; i++) begin : g_chan
      axi4_activity_pulse_chan #(
        .PULSE_LEN_CYCLES (PULSE_LEN_CYCLES),
        .GAP_LEN_CYCLES   (GAP_LEN_CYCLES),
        .MODE             (MODE)
      ) u_chan (
        .clk     (clk),
        .reset_n (reset_n),
        .act     (chan_act[i]),
        .led_on  (chan_led[i])
      );
    end
  endgenerate

  assign led_slot = chan_led[N_SLOTS-1:0] ^ {N_SLOTS{INV}};
  assign led_rd   = chan_led[N_SLOTS]     ^ INV;
  assign led_wr   = chan_led[N_SLOTS+1]   ^ INV;
  assign led_any  = chan_led[N_SLOTS+2]   ^ INV;
endmodule
